// File: rtl/gauss_filter_ctrl_pkg.sv
// Shared state encoding, tap index constants and default tap set for gauss_filter_ctrl.
// The default set is only used when GAUSS_FILTER_DEFAULT_TAPS_EN is defined.
package gauss_filter_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StStream,
        StTail
    } ctrl_state_e;

    localparam int NUM_UNIQUE_TAPS = 9;
    localparam logic [3:0] LAST_TAP_INDEX = 4'd8;
    localparam logic [3:0] GAUSS_TAP_IDLE_INDEX = 4'd15;

    // BT=0.5 half-filter, centre tap at index 8; sums to 15 over the full 17 taps.
    function automatic int default_tap(input int idx);
        case (idx)
            5: return 1;
            6: return 2;
            7, 8: return 3;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/gauss_filter_ctrl_tap_shadow.sv
// Host-writable bank of the 9 unique Gaussian taps with a single combinational read port.
// Reset contents depend on GAUSS_FILTER_DEFAULT_TAPS_EN (default set) or zero otherwise.
module gauss_filter_ctrl_tap_shadow
    import gauss_filter_ctrl_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [3:0]   wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic [3:0]   rd_addr,
    output logic [W-1:0] rd_data
);

    logic [W-1:0] taps_q [NUM_UNIQUE_TAPS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_UNIQUE_TAPS; i++) begin
`ifdef GAUSS_FILTER_DEFAULT_TAPS_EN
                taps_q[i] <= W'(default_tap(i));
`else
                taps_q[i] <= '0;
`endif
            end
        end else if (wr_en && (wr_addr <= LAST_TAP_INDEX)) begin
            taps_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (rd_addr <= LAST_TAP_INDEX) ? taps_q[rd_addr] : '0;

endmodule

// File: rtl/gauss_filter_ctrl.sv
// Tap sequencer and stream gate in front of gauss_filter: programs taps between packets
// and appends a flush tail. GAUSS_FILTER_DEFAULT_TAPS_EN enables default taps + auto-load.
module gauss_filter_ctrl
    import gauss_filter_ctrl_pkg::*;
#(
    parameter int unsigned GAUSS_FILTER_BIT_WIDTH = 5,
    parameter int unsigned NUM_TAP_GAUSS_FILTER   = 17
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_wr,
    input  logic [3:0]                        cfg_addr,
    input  logic [GAUSS_FILTER_BIT_WIDTH-1:0] cfg_data,
    input  logic                              cfg_commit,
    output logic                              cfg_busy,
    output logic                              taps_ready,
    input  logic                              in_bit,
    input  logic                              in_valid,
    input  logic                              in_valid_last,
    output logic                              in_ready,
    output logic [3:0]                        tap_index,
    output logic [GAUSS_FILTER_BIT_WIDTH-1:0] tap_value,
    output logic                              bit_upsample,
    output logic                              bit_upsample_valid,
    output logic                              bit_upsample_valid_last
);

    localparam logic [4:0] TAIL_LAST = 5'(NUM_TAP_GAUSS_FILTER - 2);

    ctrl_state_e state_q, state_d;

    logic                              reload_pending_q, reload_pending_d;
    logic                              taps_ready_q, taps_ready_d;
    logic                              cfg_busy_q, cfg_busy_d;
    logic [3:0]                        tap_index_q, tap_index_d;
    logic [GAUSS_FILTER_BIT_WIDTH-1:0] tap_value_q, tap_value_d;
    logic                              bit_q, bit_d;
    logic                              valid_q, valid_d;
    logic                              valid_last_q, valid_last_d;
    logic                              last_bit_q, last_bit_d;
    logic [4:0]                        tail_cnt_q, tail_cnt_d;

    logic                              accept, go_load, load_done, tail_done;
    logic [3:0]                        shadow_rd_addr;
    logic [GAUSS_FILTER_BIT_WIDTH-1:0] shadow_rd_data;

    gauss_filter_ctrl_tap_shadow #(
        .W (GAUSS_FILTER_BIT_WIDTH)
    ) u_tap_shadow (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cfg_wr && (state_q != StLoad)),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .rd_addr (shadow_rd_addr),
        .rd_data (shadow_rd_data)
    );

    // A commit arriving mid-packet only blocks the next packet start; stalling STREAM on it
    // would keep the packet from ever reaching its tail.
    assign in_ready = taps_ready_q &
                      (((state_q == StIdle) & ~reload_pending_q & ~cfg_commit) |
                       (state_q == StStream));

    assign accept    = in_valid & in_ready;
    assign go_load   = (state_q == StIdle) & (reload_pending_q | cfg_commit);
    assign load_done = (state_q == StLoad) && (tap_index_q == LAST_TAP_INDEX);
    assign tail_done = (state_q == StTail) && (tail_cnt_q == TAIL_LAST);

    // Read one ahead of the registered index so tap_value lines up with tap_index.
    assign shadow_rd_addr = (state_q == StLoad) ? tap_index_q + 4'd1 : 4'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (go_load) begin
                    state_d = StLoad;
                end else if (accept) begin
                    state_d = in_valid_last ? StTail : StStream;
                end
            end
            StLoad: begin
                if (load_done) state_d = StIdle;
            end
            StStream: begin
                if (accept && in_valid_last) state_d = StTail;
            end
            StTail: begin
                if (tail_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        reload_pending_d = reload_pending_q;
        if (go_load) begin
            reload_pending_d = 1'b0;
        end else if (cfg_commit) begin
            reload_pending_d = 1'b1;
        end

        taps_ready_d = taps_ready_q;
        if (load_done) begin
            taps_ready_d = 1'b1;
        end else if (state_d == StLoad) begin
            taps_ready_d = 1'b0;
        end

        cfg_busy_d  = (state_d == StLoad);
        tap_index_d = GAUSS_TAP_IDLE_INDEX;
        tap_value_d = '0;
        if (state_d == StLoad) begin
            tap_index_d = (state_q == StLoad) ? tap_index_q + 4'd1 : 4'd0;
            tap_value_d = shadow_rd_data;
        end

        bit_d        = bit_q;
        valid_d      = 1'b0;
        valid_last_d = 1'b0;
        last_bit_d   = last_bit_q;
        tail_cnt_d   = '0;
        if (accept) begin
            bit_d      = in_bit;
            valid_d    = 1'b1;
            last_bit_d = in_bit;
        end else if (state_q == StTail) begin
            bit_d        = last_bit_q;
            valid_d      = 1'b1;
            valid_last_d = tail_done;
            tail_cnt_d   = tail_cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef GAUSS_FILTER_DEFAULT_TAPS_EN
            reload_pending_q <= 1'b1;
`else
            reload_pending_q <= 1'b0;
`endif
            taps_ready_q <= 1'b0;
            cfg_busy_q   <= 1'b0;
            tap_index_q  <= GAUSS_TAP_IDLE_INDEX;
            tap_value_q  <= '0;
            bit_q        <= 1'b0;
            valid_q      <= 1'b0;
            valid_last_q <= 1'b0;
            last_bit_q   <= 1'b0;
            tail_cnt_q   <= '0;
        end else begin
            reload_pending_q <= reload_pending_d;
            taps_ready_q     <= taps_ready_d;
            cfg_busy_q       <= cfg_busy_d;
            tap_index_q      <= tap_index_d;
            tap_value_q      <= tap_value_d;
            bit_q            <= bit_d;
            valid_q          <= valid_d;
            valid_last_q     <= valid_last_d;
            last_bit_q       <= last_bit_d;
            tail_cnt_q       <= tail_cnt_d;
        end
    end

    assign cfg_busy                = cfg_busy_q;
    assign taps_ready              = taps_ready_q;
    assign tap_index               = tap_index_q;
    assign tap_value               = tap_value_q;
    assign bit_upsample            = bit_q;
    assign bit_upsample_valid      = valid_q;
    assign bit_upsample_valid_last = valid_last_q;

endmodule

// File: tb/tb_gauss_filter_ctrl.sv
// Scoreboard bench for gauss_filter_ctrl: expected tap writes and stream beats are queued
// by the stimulus and popped by a negedge monitor. Honours GAUSS_FILTER_DEFAULT_TAPS_EN.
module tb_gauss_filter_ctrl;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_wr = 1'b0;
    logic [3:0]   cfg_addr = 4'd0;
    logic [W-1:0] cfg_data = '0;
    logic         cfg_commit = 1'b0;
    logic         cfg_busy, taps_ready;
    logic         in_bit = 1'b0, in_valid = 1'b0, in_valid_last = 1'b0;
    logic         in_ready;
    logic [3:0]   tap_index;
    logic [W-1:0] tap_value;
    logic         bit_upsample, bit_upsample_valid, bit_upsample_valid_last;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int first_tap_cyc = -1;
    int last_vl_cyc = -1;
    int last_acc;

    logic [8:0]   exp_tap [$];
    logic [1:0]   exp_beat [$];
    logic [W-1:0] sh [9];

    gauss_filter_ctrl #(
        .GAUSS_FILTER_BIT_WIDTH (W),
        .NUM_TAP_GAUSS_FILTER   (17)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .cfg_wr                  (cfg_wr),
        .cfg_addr                (cfg_addr),
        .cfg_data                (cfg_data),
        .cfg_commit              (cfg_commit),
        .cfg_busy                (cfg_busy),
        .taps_ready              (taps_ready),
        .in_bit                  (in_bit),
        .in_valid                (in_valid),
        .in_valid_last           (in_valid_last),
        .in_ready                (in_ready),
        .tap_index               (tap_index),
        .tap_value               (tap_value),
        .bit_upsample            (bit_upsample),
        .bit_upsample_valid      (bit_upsample_valid),
        .bit_upsample_valid_last (bit_upsample_valid_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a tap write or a stream beat.
    always @(negedge clk) begin
        if (!rst) begin
            if (tap_index != 4'd15) begin
                if (tap_index == 4'd0) first_tap_cyc = cyc;
                if (exp_tap.size() == 0) begin
                    check("tap_unexpected", {23'd0, tap_index, tap_value}, 32'h1ff);
                end else begin
                    check("tap_write", {23'd0, tap_index, tap_value}, {23'd0, exp_tap.pop_front()});
                end
            end
            if (bit_upsample_valid) begin
                if (bit_upsample_valid_last) last_vl_cyc = cyc;
                if (exp_beat.size() == 0) begin
                    check("beat_unexpected", {30'd0, bit_upsample, bit_upsample_valid_last}, 32'h3);
                end else begin
                    check("stream_beat", {30'd0, bit_upsample, bit_upsample_valid_last},
                          {30'd0, exp_beat.pop_front()});
                end
            end else if (bit_upsample_valid_last) begin
                check("valid_last_without_valid", 32'd1, {31'd0, bit_upsample_valid});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        for (int i = 0; i < 9; i++) begin
`ifdef GAUSS_FILTER_DEFAULT_TAPS_EN
            case (i)
                5: sh[i] = 5'd1;
                6: sh[i] = 5'd2;
                7, 8: sh[i] = 5'd3;
                default: sh[i] = 5'd0;
            endcase
`else
            sh[i] = 5'd0;
`endif
        end
    endtask

    task automatic push_load(input int n);
        for (int i = 0; i < n; i++) exp_tap.push_back({4'(i), sh[i]});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tap_index"}, {28'd0, tap_index}, 32'd15);
        check({tag, "_tap_value"}, {27'd0, tap_value}, 32'd0);
        check({tag, "_cfg_busy"}, {31'd0, cfg_busy}, 32'd0);
        check({tag, "_taps_ready"}, {31'd0, taps_ready}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_bit"}, {31'd0, bit_upsample}, 32'd0);
        check({tag, "_valid"}, {31'd0, bit_upsample_valid}, 32'd0);
        check({tag, "_valid_last"}, {31'd0, bit_upsample_valid_last}, 32'd0);
    endtask

    // Called in the first cycle after reset release.
    task automatic bringup();
        int n;
        int bad;
        n = cyc;
        bad = 0;
`ifdef GAUSS_FILTER_DEFAULT_TAPS_EN
        push_load(9);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (taps_ready !== 1'b0 || in_ready !== 1'b0) bad++;
            tick();
        end
        @(negedge clk);
        check("autoload_window", bad, 0);
        check("autoload_taps_ready", {31'd0, taps_ready}, 32'd1);
        check("autoload_in_ready", {31'd0, in_ready}, 32'd1);
        check("autoload_start", first_tap_cyc, n + 1);
`else
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (taps_ready !== 1'b0 || in_ready !== 1'b0 || tap_index !== 4'd15) bad++;
            tick();
        end
        @(negedge clk);
        check("noload_window", bad, 0);
        check("noload_taps_ready", {31'd0, taps_ready}, 32'd0);
`endif
        tick();
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [W-1:0] data);
        cfg_wr = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        if (addr <= 4'd8) sh[addr] = data;
        tick();
        cfg_wr = 1'b0;
    endtask

    // Commit in IDLE; optionally attempt a shadow write in LOAD cycle wr_at (must be dropped).
    task automatic do_load(input int wr_at, input logic [3:0] wa, input logic [W-1:0] wd);
        int n;
        int bad;
        n = cyc;
        bad = 0;
        cfg_commit = 1'b1;
        push_load(9);
        @(negedge clk);
        check("commit_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        cfg_commit = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k == wr_at) begin
                cfg_wr = 1'b1;
                cfg_addr = wa;
                cfg_data = wd;
            end
            @(negedge clk);
            if (cfg_busy !== 1'b1 || in_ready !== 1'b0 || taps_ready !== 1'b0) bad++;
            tick();
            cfg_wr = 1'b0;
        end
        @(negedge clk);
        check("load_window", bad, 0);
        check("load_taps_ready", {31'd0, taps_ready}, 32'd1);
        check("load_cfg_busy", {31'd0, cfg_busy}, 32'd0);
        check("load_in_ready", {31'd0, in_ready}, 32'd1);
        check("load_start", first_tap_cyc, n + 1);
        tick();
    endtask

    task automatic send_pkt(input logic [63:0] bits, input int len, input int commit_at,
                            input int stall_at, output int acc_cyc);
        int w;
        acc_cyc = -1;
        for (int i = 0; i < len; i++) begin
            if (i == stall_at) begin
                in_valid = 1'b0;
                in_valid_last = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_bit = bits[i];
            in_valid_last = (i == len - 1);
            cfg_commit = (i == commit_at);
            exp_beat.push_back({bits[i], 1'b0});
            if (i == commit_at) push_load(9);
            w = 0;
            @(negedge clk);
            while (!in_ready && w < 40) begin
                tick();
                @(negedge clk);
                w++;
            end
            if (!in_ready) begin
                check("accept_timeout", {31'd0, in_ready}, 32'd1);
                in_valid = 1'b0;
                in_valid_last = 1'b0;
                cfg_commit = 1'b0;
                return;
            end
            acc_cyc = cyc;
            tick();
            cfg_commit = 1'b0;
        end
        in_valid = 1'b0;
        in_valid_last = 1'b0;
        for (int k = 1; k <= 16; k++) exp_beat.push_back({bits[len-1], k == 16});
    endtask

    // Called in cycle n+1 after the last accept at cycle n.
    task automatic gap_check(input int n, input logic ready_at_17);
        int bad;
        bad = 0;
        for (int c = n + 1; c <= n + 16; c++) begin
            @(negedge clk);
            if (in_ready !== 1'b0) bad++;
            tick();
        end
        @(negedge clk);
        check("gap_in_ready_low", bad, 0);
        check("gap_in_ready_n17", {31'd0, in_ready}, {31'd0, ready_at_17});
        tick();
        @(negedge clk);
        check("tail_last_beat_cycle", last_vl_cyc, n + 17);
    endtask

    initial begin
        int w;
        reset_model();
        tick();
        tick();
        @(negedge clk);
        check_reset_outputs("por");
        tick();
        rst = 1'b0;
        bringup();

        // Host programs a non-trivial tap set (sh[0] = -2) and commits it.
        cfg_write(4'd8, 5'd5);
        cfg_write(4'd7, 5'd4);
        cfg_write(4'd0, 5'h1e);
        do_load(-1, 4'd0, 5'd0);

        // 40-bit packet ending in 1, with one stall cycle before bit 20.
        send_pkt(64'h0000_00a5_3c96_0fe1, 40, -1, 20, last_acc);
        gap_check(last_acc, 1'b1);
        tick();

        // 20-bit packet ending in 0; commit lands on bit 10 and must wait for the tail.
        cfg_write(4'd3, 5'd7);
        cfg_write(4'd1, 5'h1f);
        send_pkt(64'h0000_0000_0003_a6c5, 20, 10, -1, last_acc);
        gap_check(last_acc, 1'b0);
        tick();
        @(negedge clk);
        check("deferred_load_start", first_tap_cyc, last_acc + 18);
        w = 0;
        while (!in_ready && w < 30) begin
            tick();
            @(negedge clk);
            w++;
        end
        check("deferred_load_ready", {31'd0, in_ready}, 32'd1);
        tick();

        // Write during LOAD and write to address 12 are both dropped.
        do_load(3, 4'd2, 5'd9);
        cfg_write(4'd12, 5'd6);
        do_load(-1, 4'd0, 5'd0);

        // Reset asserted in LOAD cycle 4: only taps 0..2 are ever observed.
        cfg_commit = 1'b1;
        push_load(3);
        tick();
        cfg_commit = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_load_rst");
        reset_model();
        tick();
        tick();
        rst = 1'b0;
        bringup();

        tick();
        tick();
        @(negedge clk);
        check("tap_queue_empty", exp_tap.size(), 0);
        check("beat_queue_empty", exp_beat.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
